// File: rtl/mem_arb_pkg.sv
// Shared types for the cache-subsystem memory port arbiter: response tag layout and FSM states.
package mem_arb_pkg;

   localparam int NR_PORTS = 3;
   localparam int PORT_W   = $clog2(NR_PORTS);
   localparam int TID_W    = 2;

   // Downstream tag: the port field routes the response, tid is returned to the requester.
   typedef struct packed {
      logic [PORT_W-1:0] port;
      logic [TID_W-1:0]  tid;
   } mem_tag_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } arb_state_e;

endpackage

// File: rtl/mem_port_rr_pick.sv
// Rotating-priority pick: first eligible port at or after ptr, wrapping to port 0.
module mem_port_rr_pick #(
   parameter int NrPorts = 3,
   parameter int PortW   = $clog2(NrPorts)
) (
   input  logic [NrPorts-1:0] eligible,
   input  logic [PortW-1:0]   ptr,
   output logic [PortW-1:0]   winner,
   output logic               any
);

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      winner = '0;
      any    = 1'b0;
      // First pass covers ports at or above ptr; the second pass supplies the wrapped-around ports.
      for (int i = 0; i < NrPorts; i++) begin
         if (!any && eligible[i] && (PortW'(i) >= ptr)) begin
            any    = 1'b1;
            winner = PortW'(i);
         end
      end
      for (int i = 0; i < NrPorts; i++) begin
         if (!any && eligible[i]) begin
            any    = 1'b1;
            winner = PortW'(i);
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory request channel between cache requesters, with
// per-port outstanding caps and tag-routed responses. Tag layout follows mem_arb_pkg::mem_tag_t.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NrPorts        = NR_PORTS,
   parameter int AddrWidth      = 64,
   parameter int DataWidth      = 64,
   parameter int TidWidth       = TID_W,
   parameter int MaxOutstanding = 7,
   localparam int PortW         = $clog2(NrPorts),
   localparam int TagWidth      = PortW + TidWidth
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NrPorts-1:0]             req_valid_i,
   output logic [NrPorts-1:0]             req_ready_o,
   input  logic [NrPorts*AddrWidth-1:0]   req_addr_i,
   input  logic [NrPorts-1:0]             req_we_i,
   input  logic [NrPorts*DataWidth-1:0]   req_wdata_i,
   input  logic [NrPorts*TidWidth-1:0]    req_tid_i,
   output logic                           mem_req_valid_o,
   input  logic                           mem_req_ready_i,
   output logic [AddrWidth-1:0]           mem_req_addr_o,
   output logic                           mem_req_we_o,
   output logic [DataWidth-1:0]           mem_req_wdata_o,
   output logic [TagWidth-1:0]            mem_req_tag_o,
   input  logic                           mem_rsp_valid_i,
   input  logic [TagWidth-1:0]            mem_rsp_tag_i,
   input  logic [DataWidth-1:0]           mem_rsp_rdata_i,
   output logic [NrPorts-1:0]             rsp_valid_o,
   output logic [TidWidth-1:0]            rsp_tid_o,
   output logic [DataWidth-1:0]           rsp_rdata_o,
   output logic                           idle_o,
   output logic                           err_o
);

   localparam int CntW = $clog2(MaxOutstanding + 1);
   localparam logic [CntW-1:0]  CNT_MAX   = CntW'(MaxOutstanding);
   localparam logic [PortW-1:0] LAST_PORT = PortW'(NrPorts - 1);

   arb_state_e           state_q, state_d;
   logic [PortW-1:0]     ptr_q;
   logic [PortW-1:0]     winner;
   logic                 any;
   logic                 accept;
   logic [NrPorts-1:0]   eligible;
   logic [NrPorts-1:0]   cnt_zero;
   logic [NrPorts-1:0]   rsp_hit;
   logic                 err_q;
   logic                 err_set;
   mem_tag_t             rsp_tag;

   logic [AddrWidth-1:0] addr_arr  [NrPorts];
   logic [DataWidth-1:0] wdata_arr [NrPorts];
   logic [TidWidth-1:0]  tid_arr   [NrPorts];

   assign rsp_tag = mem_rsp_tag_i;

   for (genvar g = 0; g < NrPorts; g++) begin : g_port
      logic [CntW-1:0] cnt_q;
      logic            inc;
      logic            dec;

      assign addr_arr[g]  = req_addr_i[g*AddrWidth +: AddrWidth];
      assign wdata_arr[g] = req_wdata_i[g*DataWidth +: DataWidth];
      assign tid_arr[g]   = req_tid_i[g*TidWidth +: TidWidth];

      assign eligible[g] = req_valid_i[g] && (cnt_q < CNT_MAX);
      assign rsp_hit[g]  = mem_rsp_valid_i && (rsp_tag.port == PortW'(g));
      assign cnt_zero[g] = (cnt_q == '0);
      assign inc         = accept && (winner == PortW'(g));
      // A response against an empty counter is flagged as an error, never allowed to underflow.
      assign dec         = rsp_hit[g] && !cnt_zero[g];

      // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            cnt_q <= '0;
         end else if (inc && !dec) begin
            cnt_q <= cnt_q + CntW'(1);
         end else if (dec && !inc) begin
            cnt_q <= cnt_q - CntW'(1);
         end
      end
   end

   mem_port_rr_pick #(
      .NrPorts (NrPorts),
      .PortW   (PortW)
   ) i_pick (
      .eligible (eligible),
      .ptr      (ptr_q),
      .winner   (winner),
      .any      (any)
   );

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (any) begin
               accept  = 1'b1;
               state_d = FULL;
            end
         end
         FULL: begin
            // A draining slot is refilled in the same cycle, giving one request per cycle.
            if (mem_req_ready_i) begin
               accept  = any;
               state_d = any ? FULL : EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      req_ready_o = '0;
      for (int i = 0; i < NrPorts; i++) begin
         req_ready_o[i] = accept && (winner == PortW'(i));
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= EMPTY;
         ptr_q           <= '0;
         mem_req_addr_o  <= '0;
         mem_req_we_o    <= 1'b0;
         mem_req_wdata_o <= '0;
         mem_req_tag_o   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            ptr_q           <= (winner == LAST_PORT) ? '0 : winner + PortW'(1);
            mem_req_addr_o  <= addr_arr[winner];
            mem_req_we_o    <= req_we_i[winner];
            mem_req_wdata_o <= wdata_arr[winner];
            mem_req_tag_o   <= {winner, tid_arr[winner]};
         end
      end
   end

   // Unknown port numbers and responses with nothing outstanding both land here.
   assign err_set = mem_rsp_valid_i && ((rsp_hit == '0) || ((rsp_hit & cnt_zero) != '0));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if (err_set) begin
         err_q <= 1'b1;
      end
   end

   assign mem_req_valid_o = (state_q == FULL);
   assign rsp_valid_o     = rsp_hit;
   assign rsp_tid_o       = rsp_tag.tid;
   assign rsp_rdata_o     = mem_rsp_rdata_i;
   assign idle_o          = (state_q == EMPTY) && (&cnt_zero);
   assign err_o           = err_q;

endmodule
